// File: rtl/unlock_pkg.sv
// Shared types and constants for the unlock client: FSM states, failure codes,
// the protocol separator and the fixed unlock key.
package unlock_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT,
        SEP,
        RECV,
        DONE,
        ERR
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ECHO    = 2'd1;
    localparam logic [1:0] ERR_SEP     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] SEP_BYTE = 8'h00;

    // "v3ril0g_1s_pain_peko"
    localparam int KEY_BYTES = 20;
    localparam logic [7:0] UNLOCK_KEY [KEY_BYTES] = '{
        8'h76, 8'h33, 8'h72, 8'h69, 8'h6c, 8'h30, 8'h67, 8'h5f, 8'h31, 8'h73,
        8'h5f, 8'h70, 8'h61, 8'h69, 8'h6e, 8'h5f, 8'h70, 8'h65, 8'h6b, 8'h6f
    };

endpackage

// File: rtl/unlock_client_if.sv
// UART byte streams plus the payload output stream of the unlock client.
// master = the client, slave = the UART/consumer side.
interface unlock_client_if;

    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       tx_active;
    logic       tx_done;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       resp_valid;
    logic [7:0] resp_byte;
    logic       resp_last;

    modport master (
        output tx_dv, tx_byte, resp_valid, resp_byte, resp_last,
        input  tx_active, tx_done, rx_dv, rx_byte
    );

    modport slave (
        input  tx_dv, tx_byte, resp_valid, resp_byte, resp_last,
        output tx_active, tx_done, rx_dv, rx_byte
    );

endinterface

// File: rtl/unlock_timeout.sv
// Idle watchdog: counts cycles while run is high, cleared by reload; expired is
// combinational and rises on the TIMEOUT_CYC-th cycle after the last reload.
module unlock_timeout #(
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic clk,
    input  logic n_rst,
    input  logic reload,
    input  logic run,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt;

    assign expired = run && (cnt == CNT_W'(TIMEOUT_CYC - 1));

    // Holds at the terminal count so a stalled consumer of expired never sees a wrap.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt <= '0;
        end else if (reload) begin
            cnt <= '0;
        end else if (run && !expired) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/unlock_client.sv
// Sends the unlock key byte-by-byte with echo check, then streams the payload out
// with one cycle of latency; tx waits while tx_active, no backpressure on resp.
module unlock_client
    import unlock_pkg::*;
#(
    parameter int KEY_LEN     = 20,
    parameter int PAYLOAD_LEN = 39,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code,
    unlock_client_if.master  uart
);
    localparam int IDX_W = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
    localparam int CNT_W = $clog2(PAYLOAD_LEN + 1);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [CNT_W-1:0] pcnt, pcnt_nxt;
    logic             echo_seen, echo_seen_nxt;
    logic             txd_seen, txd_seen_nxt;
    logic [1:0]       err_code_nxt;
    logic             tx_dv_nxt;
    logic [7:0]       tx_byte_nxt;
    logic             resp_valid_nxt, resp_last_nxt;
    logic [7:0]       resp_byte_nxt;
    logic [7:0]       key_cur;
    logic             evt, to_reload, to_expired;

    assign key_cur = UNLOCK_KEY[idx];
    assign busy    = (state == SEND) || (state == WAIT) || (state == SEP) || (state == RECV);
    assign done    = (state == DONE);
    assign err     = (state == ERR);

    // Every state change and every accepted UART event restarts the idle window.
    assign to_reload = (state_nxt != state) || evt;

    unlock_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .n_rst   (n_rst),
        .reload  (to_reload),
        .run     (busy),
        .expired (to_expired)
    );

    always_comb begin
        state_nxt      = state;
        idx_nxt        = idx;
        pcnt_nxt       = pcnt;
        echo_seen_nxt  = echo_seen;
        txd_seen_nxt   = txd_seen;
        err_code_nxt   = err_code;
        tx_dv_nxt      = 1'b0;
        tx_byte_nxt    = uart.tx_byte;
        resp_valid_nxt = 1'b0;
        resp_byte_nxt  = uart.resp_byte;
        resp_last_nxt  = 1'b0;
        evt            = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt    = SEND;
                    idx_nxt      = '0;
                    pcnt_nxt     = '0;
                    err_code_nxt = ERR_NONE;
                end
            end
            SEND: begin
                if (!uart.tx_active) begin
                    tx_dv_nxt     = 1'b1;
                    tx_byte_nxt   = key_cur;
                    echo_seen_nxt = 1'b0;
                    txd_seen_nxt  = 1'b0;
                    state_nxt     = WAIT;
                end else if (to_expired) begin
                    state_nxt    = ERR;
                    err_code_nxt = ERR_TIMEOUT;
                end
            end
            WAIT: begin
                evt = uart.rx_dv || uart.tx_done;
                // Any echo after the first one is as wrong as a corrupted echo.
                if (uart.rx_dv && (echo_seen || (uart.rx_byte != key_cur))) begin
                    state_nxt    = ERR;
                    err_code_nxt = ERR_ECHO;
                end else if ((echo_seen || uart.rx_dv) && (txd_seen || uart.tx_done)) begin
                    if (idx == IDX_W'(KEY_LEN - 1)) begin
                        state_nxt = SEP;
                    end else begin
                        idx_nxt   = idx + IDX_W'(1);
                        state_nxt = SEND;
                    end
                end else if (evt) begin
                    echo_seen_nxt = echo_seen || uart.rx_dv;
                    txd_seen_nxt  = txd_seen || uart.tx_done;
                end else if (to_expired) begin
                    state_nxt    = ERR;
                    err_code_nxt = ERR_TIMEOUT;
                end
            end
            SEP: begin
                evt = uart.rx_dv;
                if (uart.rx_dv) begin
                    if (uart.rx_byte == SEP_BYTE) begin
                        state_nxt = RECV;
                    end else begin
                        state_nxt    = ERR;
                        err_code_nxt = ERR_SEP;
                    end
                end else if (to_expired) begin
                    state_nxt    = ERR;
                    err_code_nxt = ERR_TIMEOUT;
                end
            end
            RECV: begin
                evt = uart.rx_dv;
                if (uart.rx_dv) begin
                    resp_valid_nxt = 1'b1;
                    resp_byte_nxt  = uart.rx_byte;
                    pcnt_nxt       = pcnt + CNT_W'(1);
                    if (pcnt == CNT_W'(PAYLOAD_LEN - 1)) begin
                        resp_last_nxt = 1'b1;
                        state_nxt     = DONE;
                    end
                end else if (to_expired) begin
                    state_nxt    = ERR;
                    err_code_nxt = ERR_TIMEOUT;
                end
            end
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state           <= IDLE;
            idx             <= '0;
            pcnt            <= '0;
            echo_seen       <= 1'b0;
            txd_seen        <= 1'b0;
            err_code        <= ERR_NONE;
            uart.tx_dv      <= 1'b0;
            uart.tx_byte    <= '0;
            uart.resp_valid <= 1'b0;
            uart.resp_byte  <= '0;
            uart.resp_last  <= 1'b0;
        end else begin
            state           <= state_nxt;
            idx             <= idx_nxt;
            pcnt            <= pcnt_nxt;
            echo_seen       <= echo_seen_nxt;
            txd_seen        <= txd_seen_nxt;
            err_code        <= err_code_nxt;
            uart.tx_dv      <= tx_dv_nxt;
            uart.tx_byte    <= tx_byte_nxt;
            uart.resp_valid <= resp_valid_nxt;
            uart.resp_byte  <= resp_byte_nxt;
            uart.resp_last  <= resp_last_nxt;
        end
    end

endmodule

// File: tb/tb_unlock_client.sv
// Randomised bench for unlock_client: a UART/server model answers each key byte with
// random echo/tx_done ordering, and results are checked against the protocol rules.
module tb_unlock_client;

    localparam int KEY_LEN     = 20;
    localparam int PAYLOAD_LEN = 39;
    localparam int TIMEOUT_CYC = 100;
    localparam int BUDGET      = 4000;

    logic       clk   = 1'b0;
    logic       n_rst = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, err;
    logic [1:0] err_code;

    unlock_client_if uart_if ();

    unlock_client #(
        .KEY_LEN     (KEY_LEN),
        .PAYLOAD_LEN (PAYLOAD_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_code (err_code),
        .uart     (uart_if)
    );

    always #5 clk = ~clk;

    string key = "v3ril0g_1s_pain_peko";
    string pfx = "pbctf{";

    int n_chk = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // scenario knobs
    int         k_bad_idx, k_dup_idx, k_stop_idx, k_order, k_gap_idx, k_rst_resp, k_extra_start;
    logic [7:0] k_bad_val, k_sep;

    // observations and model expectations of one transaction
    logic [7:0] tx_got[$];
    logic [7:0] resp_got[$];
    logic [7:0] exp_pay[$];
    int n_last, last_pos, last_at, n_done, done_at, n_err, err_at, code_at_err;
    int code_first_tx, viol_active, viol_busy, exp_err_at;
    bit finished;

    task automatic knobs_default();
        k_bad_idx = -1; k_dup_idx = -1; k_stop_idx = -1; k_order = 0;
        k_gap_idx = -1; k_rst_resp = 0; k_extra_start = -1;
        k_bad_val = 8'h00; k_sep = 8'h00;
    endtask

    task automatic serve();
        int cyc, txd_at, act_until, post, de, dd, t;
        int rx_at[$];
        logic [7:0] rx_val[$];
        logic prev_act;
        cyc = 0; txd_at = -1; act_until = -1; post = 0; finished = 0;
        tx_got.delete(); resp_got.delete(); exp_pay.delete();
        n_last = 0; last_pos = -1; last_at = -1; n_done = 0; done_at = -1;
        n_err = 0; err_at = -1; code_at_err = -1; code_first_tx = -1;
        viol_active = 0; viol_busy = 0; exp_err_at = -1;
        for (int p = 0; p < PAYLOAD_LEN; p++) begin
            if (p < 6)                     exp_pay.push_back(pfx[p]);
            else if (p == PAYLOAD_LEN - 1) exp_pay.push_back(8'h7d);
            else                           exp_pay.push_back(8'($urandom_range(33, 126)));
        end

        while (post < 20 && cyc < BUDGET) begin
            start             = (cyc == 0) || (cyc == k_extra_start);
            uart_if.tx_done   = (cyc == txd_at);
            uart_if.tx_active = (cyc <= act_until);
            uart_if.rx_dv     = 1'b0;
            uart_if.rx_byte   = 8'($urandom);
            if (rx_at.size() != 0 && rx_at[0] == cyc) begin
                uart_if.rx_dv   = 1'b1;
                uart_if.rx_byte = rx_val[0];
                void'(rx_at.pop_front());
                void'(rx_val.pop_front());
            end
            prev_act = uart_if.tx_active;
            @(negedge clk);
            cyc++;

            if (uart_if.tx_dv) begin
                int i;
                i = tx_got.size();
                if (prev_act) viol_active++;
                if (code_first_tx < 0) code_first_tx = int'(err_code);
                tx_got.push_back(uart_if.tx_byte);
                if (i == k_stop_idx) begin
                    // server goes silent: error after a full idle window from WAIT entry
                    exp_err_at = cyc + TIMEOUT_CYC;
                end else if (i < KEY_LEN) begin
                    dd = int'($urandom_range(2, 6));
                    case (k_order)
                        1:       de = dd;
                        2:       de = dd - 2;
                        default: de = dd + int'($urandom_range(0, 4)) - 2;
                    endcase
                    if (i == k_dup_idx) begin
                        rx_at.push_back(cyc + de);     rx_val.push_back(key[i]);
                        rx_at.push_back(cyc + de + 1); rx_val.push_back(key[i]);
                        dd = de + 3;
                        exp_err_at = cyc + de + 2;
                    end else begin
                        rx_at.push_back(cyc + de);
                        rx_val.push_back((i == k_bad_idx) ? k_bad_val : key[i]);
                        if (i == k_bad_idx) exp_err_at = cyc + de + 1;
                    end
                    txd_at    = cyc + dd;
                    act_until = cyc + dd + int'($urandom_range(0, 2));
                    if (i == KEY_LEN - 1) begin
                        t = cyc + ((de > dd) ? de : dd) + 1 + int'($urandom_range(0, 3));
                        rx_at.push_back(t); rx_val.push_back(k_sep);
                        if (k_sep != 8'h00) exp_err_at = t + 1;
                        for (int p = 0; p < PAYLOAD_LEN; p++) begin
                            t += (p == k_gap_idx) ? 95 : int'($urandom_range(1, 4));
                            rx_at.push_back(t); rx_val.push_back(exp_pay[p]);
                        end
                    end
                end
            end
            if (uart_if.resp_valid) begin
                resp_got.push_back(uart_if.resp_byte);
                if (uart_if.resp_last) begin
                    n_last++;
                    last_pos = resp_got.size() - 1;
                    last_at  = cyc;
                end
            end else if (uart_if.resp_last) begin
                n_last++;
            end
            if ((uart_if.tx_dv || (uart_if.resp_valid && !uart_if.resp_last)) && !busy) viol_busy++;
            if ((done || err) && busy) viol_busy++;
            if (done) begin n_done++; done_at = cyc; end
            if (err)  begin n_err++;  err_at = cyc; code_at_err = int'(err_code); end

            if (k_rst_resp > 0 && resp_got.size() == k_rst_resp) begin
                n_rst = 1'b0;
                #1;
                check_eq("reset_outputs_zero",
                         {uart_if.tx_dv, uart_if.tx_byte, busy, uart_if.resp_valid,
                          uart_if.resp_byte, uart_if.resp_last, done, err, err_code}, 0);
                repeat (3) begin
                    @(negedge clk);
                    if (done) n_done++;
                    if (err)  n_err++;
                end
                n_rst = 1'b1;
                break;
            end
            if (finished) post++;
            if (done || err) finished = 1'b1;
        end
        start             = 1'b0;
        uart_if.tx_done   = 1'b0;
        uart_if.tx_active = 1'b0;
        uart_if.rx_dv     = 1'b0;
    endtask

    task automatic check_result(input string name, input int exp_ntx, input int exp_nresp,
                                input int exp_done, input int exp_err, input int exp_code);
        int mism;
        check_eq({name, ":tx_count"}, tx_got.size(), exp_ntx);
        mism = 0;
        foreach (tx_got[i]) if (i >= KEY_LEN || tx_got[i] !== key[i]) mism++;
        check_eq({name, ":tx_bytes_wrong"}, mism, 0);
        check_eq({name, ":resp_count"}, resp_got.size(), exp_nresp);
        mism = 0;
        foreach (resp_got[i]) if (i >= PAYLOAD_LEN || resp_got[i] !== exp_pay[i]) mism++;
        check_eq({name, ":resp_bytes_wrong"}, mism, 0);
        check_eq({name, ":resp_last_count"}, n_last, (exp_nresp == PAYLOAD_LEN) ? 1 : 0);
        if (exp_nresp == PAYLOAD_LEN) begin
            check_eq({name, ":resp_last_pos"}, last_pos, PAYLOAD_LEN - 1);
            check_eq({name, ":done_not_before_last"}, (done_at >= last_at) ? 1 : 0, 1);
        end
        check_eq({name, ":done_pulses"}, n_done, exp_done);
        check_eq({name, ":err_pulses"}, n_err, exp_err);
        if (exp_err != 0) begin
            check_eq({name, ":err_code"}, code_at_err, exp_code);
            check_eq({name, ":err_cycle"}, err_at, exp_err_at);
        end
        check_eq({name, ":err_code_cleared_on_start"}, code_first_tx, 0);
        check_eq({name, ":tx_while_active"}, viol_active, 0);
        check_eq({name, ":busy_wrong"}, viol_busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int junk;
        uart_if.tx_active = 1'b0;
        uart_if.tx_done   = 1'b0;
        uart_if.rx_dv     = 1'b0;
        uart_if.rx_byte   = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("reset_values",
                 {uart_if.tx_dv, uart_if.tx_byte, busy, uart_if.resp_valid,
                  uart_if.resp_byte, uart_if.resp_last, done, err, err_code}, 0);
        n_rst = 1'b1;
        @(negedge clk);

        // UART activity while idle must not leak to any output
        junk = 0;
        for (int c = 0; c < 8; c++) begin
            uart_if.rx_dv   = c[0];
            uart_if.rx_byte = 8'($urandom);
            uart_if.tx_done = 1'($urandom);
            @(negedge clk);
            if (uart_if.resp_valid || uart_if.tx_dv || busy || done || err) junk++;
        end
        uart_if.rx_dv = 1'b0; uart_if.tx_done = 1'b0;
        check_eq("idle_rx_ignored", junk, 0);

        knobs_default(); k_extra_start = 40; serve();
        check_result("normal_random_order", KEY_LEN, PAYLOAD_LEN, 1, 0, 0);
        knobs_default(); k_order = 1; serve();
        check_result("echo_same_cycle", KEY_LEN, PAYLOAD_LEN, 1, 0, 0);
        knobs_default(); k_order = 2; serve();
        check_result("echo_2_early", KEY_LEN, PAYLOAD_LEN, 1, 0, 0);
        knobs_default(); k_bad_idx = 4; k_bad_val = 8'h00; serve();
        check_result("bad_echo", 5, 0, 0, 1, 1);
        check_eq("err_code_held", err_code, 1);
        knobs_default(); k_sep = 8'h41; serve();
        check_result("bad_separator", KEY_LEN, 0, 0, 1, 2);
        knobs_default(); k_stop_idx = 3; serve();
        check_result("timeout", 4, 0, 0, 1, 3);
        check_eq("err_code_held_timeout", err_code, 3);
        knobs_default(); k_dup_idx = 7; serve();
        check_result("duplicate_echo", 8, 0, 0, 1, 1);
        knobs_default(); k_gap_idx = 20; serve();
        check_result("long_gap_no_timeout", KEY_LEN, PAYLOAD_LEN, 1, 0, 0);
        knobs_default(); k_rst_resp = 10; serve();
        check_result("reset_in_recv", KEY_LEN, 10, 0, 0, 0);
        knobs_default(); serve();
        check_result("after_reset", KEY_LEN, PAYLOAD_LEN, 1, 0, 0);
        for (int r = 0; r < 3; r++) begin
            knobs_default(); k_gap_idx = int'($urandom_range(0, 60)); serve();
            check_result("random_normal", KEY_LEN, PAYLOAD_LEN, 1, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/unlock_client.md
UNLOCK_CLIENT -- requirements
Module: unlock_client

Interface
REQ-001 Parameter KEY_LEN, default 20, number of key bytes sent.
REQ-002 Parameter PAYLOAD_LEN, default 39, number of payload bytes expected after the 0x00 separator.
REQ-003 Parameter TIMEOUT_CYC, default 1000000, maximum idle cycles allowed in any wait.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 n_rst  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  one-cycle request to begin an unlock transaction.
REQ-007 tx_dv  out  1  one-cycle send strobe to the UART transmitter.
REQ-008 tx_byte  out  8  byte to send; valid when tx_dv=1.
REQ-009 tx_active  in  1  UART transmitter busy.
REQ-010 tx_done  in  1  one-cycle pulse at the end of a transmitted frame.
REQ-011 rx_dv  in  1  one-cycle pulse for a received byte.
REQ-012 rx_byte  in  8  received byte; valid when rx_dv=1.
REQ-013 busy  out  1  high from accepted start until DONE or ERR.
REQ-014 resp_valid  out  1  one-cycle strobe for a payload byte.
REQ-015 resp_byte  out  8  payload byte.
REQ-016 resp_last  out  1  high with the final payload strobe.
REQ-017 done  out  1  one-cycle pulse on successful completion.
REQ-018 err  out  1  one-cycle pulse on failure.
REQ-019 err_code  out  2  failure cause, held until the next start: 1 echo mismatch, 2 bad separator, 3 timeout.

Function
REQ-020 The FSM SHALL have states IDLE, SEND, WAIT, SEP, RECV, DONE, ERR.
REQ-021 IDLE: start=1 -> SEND; busy=1, key index=0, err_code=0. start in any other state SHALL be ignored.
REQ-022 SEND: tx_dv SHALL pulse for one cycle with tx_byte=UNLOCK_KEY[idx], only when tx_active=0; then -> WAIT.
REQ-023 WAIT: tx_done and the echo rx_dv SHALL be accepted in either order or in the same cycle; leave only when both have been seen.
REQ-024 An echo byte that differs from the sent byte SHALL cause -> ERR with code 1.
REQ-025 After both events with idx<KEY_LEN-1: idx++, -> SEND. With idx=KEY_LEN-1: -> SEP.
REQ-026 SEP: rx_byte==0x00 -> RECV; any other value -> ERR with code 2.
REQ-027 RECV: each rx_dv SHALL produce resp_valid=1 with resp_byte=rx_byte in the next cycle (registered, 1-cycle latency).
REQ-028 RECV: the PAYLOAD_LEN-th strobe SHALL assert resp_last; the next state SHALL be DONE.
REQ-029 DONE and ERR SHALL each last one cycle, pulse done or err, clear busy, and return to IDLE.
REQ-030 Timeout: a counter SHALL reload on entry to every state and on every accepted rx_dv/tx_done; reaching TIMEOUT_CYC in SEND, WAIT, SEP or RECV -> ERR with code 3.
REQ-031 rx_dv in IDLE SHALL be discarded, with no output effect.
REQ-032 A second rx_dv in WAIT after the echo was already captured SHALL be treated as a mismatch (code 1).
REQ-033 Byte and payload counters SHALL be sized with $clog2 and SHALL never wrap within a transaction.

Reset
REQ-034 While n_rst=0: state=IDLE; all counters 0; tx_dv, busy, resp_valid, resp_last, done, err = 0; tx_byte, resp_byte, err_code = 0.
REQ-035 Reset mid-transaction SHALL abort immediately with no done or err pulse; bytes already in flight in the UART are not the block's concern.

Structure
REQ-036 Package unlock_pkg SHALL hold the state enum, the err_code localparams, the separator constant 0x00, and UNLOCK_KEY (20-byte array, "v3ril0g_1s_pain_peko").
REQ-037 One sub-module, unlock_timeout, SHALL implement the reloadable timeout counter (inputs reload, run; output expired).
REQ-038 UART rx/tx instances SHALL live in the top level, not inside unlock_client.

Verification
REQ-039 Scenario: start with a model server echoing bytes, then sending 0x76 echo, 0x00, and 39 bytes "pbctf{...}" -> 20 tx_dv strobes (first 0x76, last 0x6f), 39 resp_valid strobes, resp_last on the 39th, then one done pulse.
REQ-040 Scenario: the echo to byte 5 returns 0x00 instead of 0x6c -> err pulse, err_code=1, no further tx_dv.
REQ-041 Scenario: the byte after the final echo is 0x41 -> err, err_code=2.
REQ-042 Scenario: the server stops after byte 3 with TIMEOUT_CYC=100 -> err exactly 100 cycles after the last event, err_code=3.
REQ-043 Scenario: the echo arrives in the same cycle as tx_done, and also 2 cycles before tx_done -> both cases advance normally.
REQ-044 Scenario: n_rst asserted during RECV, then start again -> clean restart, no done or err from the aborted run, all outputs at reset values during reset.
